line_buf_sched: RTL and testbench

LINE_BUF_SCHED -- requirements
Module: line_buf_sched

---
 rtl/line_buf_pkg.sv | 24 ++
 rtl/line_bank.sv | 28 ++
 rtl/line_buf_sched.sv | 161 ++++++++++++++++
 tb/tb_line_buf_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// Shared types and defaults for the double-banked line capture/display scheduler.
package line_buf_pkg;

    localparam int unsigned LINE_PIX_DEF   = 90;
    localparam int unsigned CAP_SHIFT_DEF  = 2;
    localparam int unsigned DISP_SHIFT_DEF = 2;
    localparam int unsigned SC_W           = 12;
    localparam int unsigned H_W            = 11;

    localparam logic [SC_W-1:0] SC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DEN  = 2'd1,
        CAPTURE   = 2'd2,
        PEND_SWAP = 2'd3
    } state_t;

    // Index width for a bank of n bits, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_bank.sv
// One line bank: W-bit register, single-bit write port, combinational read port.
module line_bank #(
    parameter int unsigned W  = 90,
    parameter int unsigned IW = 7
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic          wbit,
    input  logic [IW-1:0] ridx,
    output logic          rbit_c
);

    logic [W-1:0] mem;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            mem <= '0;
        end else if (we && (32'(widx) < W)) begin
            mem[widx] <= wbit;
        end
    end

    // Out-of-range reads return zero rather than an undefined bit.
    assign rbit_c = (32'(ridx) < W) ? mem[ridx] : 1'b0;

endmodule

// File: rtl/line_buf_sched.sv
// Captures one decimated source line into the write bank while the read bank feeds
// the display; banks swap only at a display line end once a capture has finished.
module line_buf_sched
    import line_buf_pkg::*;
#(
    parameter int unsigned LINE_PIX   = LINE_PIX_DEF,
    parameter int unsigned CAP_SHIFT  = CAP_SHIFT_DEF,
    parameter int unsigned DISP_SHIFT = DISP_SHIFT_DEF
) (
    input  logic           clk_in,
    input  logic           reset,
    input  logic           arm,
    input  logic           cap_den,
    input  logic           cap_stb,
    input  logic           cap_bit,
    input  logic           disp_en,
    input  logic [H_W-1:0] disp_h,
    input  logic           line_end,
    output logic           pixel,
    output logic           busy,
    output logic           swapped,
    output logic           overflow
);

    localparam int unsigned IW = idx_w(LINE_PIX);
    localparam logic [SC_W-1:0] CAP_MASK = SC_W'((1 << CAP_SHIFT) - 1);

    state_t          state;
    state_t          state_nxt;
    logic            wr_sel;
    logic [SC_W-1:0] sc;

    logic            take_c;
    logic            clr_c;
    logic            swap_c;
    logic [SC_W-1:0] cap_idx_c;
    logic            on_grid_c;
    logic            idx_ok_c;
    logic            wr_c;
    logic            ovf_set_c;
    logic [H_W-1:0]  disp_idx_c;
    logic            disp_ok_c;
    logic [IW-1:0]   ridx_c;
    logic            rbit0_c;
    logic            rbit1_c;
    logic            rd_bit_c;

    // Strobe index -> stored-bit index; only every 2^CAP_SHIFT-th strobe is kept.
    assign cap_idx_c = sc >> CAP_SHIFT;
    assign on_grid_c = ((sc & CAP_MASK) == '0);
    assign idx_ok_c  = (32'(cap_idx_c) < LINE_PIX);
    assign wr_c      = take_c && on_grid_c && idx_ok_c;
    assign ovf_set_c = take_c && on_grid_c && !idx_ok_c;

    // Next-state and per-cycle control.
    always_comb begin
        state_nxt = state;
        take_c    = 1'b0;
        clr_c     = 1'b0;
        swap_c    = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = WAIT_DEN;
                    clr_c     = 1'b1;
                end
            end
            WAIT_DEN: begin
                if (cap_den) begin
                    state_nxt = CAPTURE;
                    take_c    = cap_stb;
                end
            end
            CAPTURE: begin
                if (!cap_den) begin
                    state_nxt = PEND_SWAP;
                end else begin
                    take_c = cap_stb;
                end
            end
            PEND_SWAP: begin
                if (line_end) begin
                    state_nxt = IDLE;
                    swap_c    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= IDLE;
            wr_sel   <= 1'b0;
            sc       <= '0;
            overflow <= 1'b0;
            swapped  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt != IDLE);
            swapped <= swap_c;
            if (swap_c) begin
                wr_sel <= ~wr_sel;
            end
            if (clr_c) begin
                sc       <= '0;
                overflow <= 1'b0;
            end else if (take_c) begin
                if (sc != SC_MAX) begin
                    sc <= sc + SC_W'(1);
                end
                if (ovf_set_c) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Display side: each stored bit spans 2^DISP_SHIFT h-counts.
    assign disp_idx_c = disp_h >> DISP_SHIFT;
    assign disp_ok_c  = disp_en && (32'(disp_idx_c) < LINE_PIX);
    assign ridx_c     = IW'(disp_idx_c);
    assign rd_bit_c   = wr_sel ? rbit0_c : rbit1_c;

    // wr_sel still holds its old value on the swap edge, so that cycle reads the old bank.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pixel <= 1'b0;
        end else begin
            pixel <= disp_ok_c & rd_bit_c;
        end
    end

    line_bank #(
        .W  (LINE_PIX),
        .IW (IW)
    ) u_bank0 (
        .clk_in (clk_in),
        .reset  (reset),
        .we     (wr_c && !wr_sel),
        .widx   (IW'(cap_idx_c)),
        .wbit   (cap_bit),
        .ridx   (ridx_c),
        .rbit_c (rbit0_c)
    );

    line_bank #(
        .W  (LINE_PIX),
        .IW (IW)
    ) u_bank1 (
        .clk_in (clk_in),
        .reset  (reset),
        .we     (wr_c && wr_sel),
        .widx   (IW'(cap_idx_c)),
        .wbit   (cap_bit),
        .ridx   (ridx_c),
        .rbit_c (rbit1_c)
    );

endmodule

// File: tb/tb_line_buf_sched.sv
// Scenario bench for line_buf_sched: a bank model predicts pixel/overflow/swap behaviour.
module tb_line_buf_sched;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        arm;
    logic        cap_den;
    logic        cap_stb;
    logic        cap_bit;
    logic        disp_en;
    logic [10:0] disp_h;
    logic        line_end;
    logic        pixel;
    logic        busy;
    logic        swapped;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    // Model: m_b0/m_b1 are the banks, m_sel the write-bank select.
    logic [89:0] m_b0;
    logic [89:0] m_b1;
    bit          m_sel;
    bit          m_ovf;
    bit          pq[$];

    line_buf_sched dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .arm      (arm),
        .cap_den  (cap_den),
        .cap_stb  (cap_stb),
        .cap_bit  (cap_bit),
        .disp_en  (disp_en),
        .disp_h   (disp_h),
        .line_end (line_end),
        .pixel    (pixel),
        .busy     (busy),
        .swapped  (swapped),
        .overflow (overflow)
    );

    always #5 clk_in = ~clk_in;

    function automatic bit exp_pix(input bit en, input int h);
        int k;
        logic [89:0] rd;
        k  = h >> 2;
        rd = m_sel ? m_b0 : m_b1;
        if (!en || k >= 90) return 1'b0;
        return rd[k];
    endfunction

    task automatic sweep(input bit en, input string tag);
        int  nf = 0;
        bit  e;
        pq.delete();
        for (int h = 0; h < 800; h++) begin
            disp_en = en;
            disp_h  = 11'(h);
            pq.push_back(exp_pix(en, h));
            @(negedge clk_in);
            e = pq.pop_front();
            total++;
            if (pixel !== e) begin
                bad++;
                if (nf < 5) $display("FAIL %s pixel h=%0d got=%b want=%b", tag, h, pixel, e);
                nf++;
            end
        end
        disp_en = 1'b0;
        disp_h  = '0;
    endtask

    task automatic capture(input int n, input bit rnd, input int abort_at,
                           input bit do_arm, input bit hold_arm, input string tag);
        bit b;
        if (do_arm) begin
            arm = 1'b1;
            @(negedge clk_in);
            arm   = hold_arm;
            m_ovf = 1'b0;
            total++;
            if (overflow !== 1'b0) begin
                bad++;
                $display("FAIL %s overflow_after_arm got=%b want=0", tag, overflow);
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL %s busy_after_arm got=%b want=1", tag, busy);
            end
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                cap_stb = 1'b0;
                reset   = 1'b1;
                @(negedge clk_in);
                reset   = 1'b0;
                cap_den = 1'b0;
                arm     = 1'b0;
                m_b0    = '0;
                m_b1    = '0;
                m_sel   = 1'b0;
                m_ovf   = 1'b0;
                return;
            end
            b = rnd ? 1'($urandom) : 1'((i >> 2) & 1);
            cap_den = 1'b1;
            cap_stb = 1'b1;
            cap_bit = b;
            if (i % 4 == 0) begin
                if (i / 4 < 90) begin
                    if (m_sel) m_b1[i/4] = b;
                    else       m_b0[i/4] = b;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            @(negedge clk_in);
            cap_stb = 1'b0;
            @(negedge clk_in);
            total++;
            if (overflow !== m_ovf) begin
                bad++;
                $display("FAIL %s overflow strobe=%0d got=%b want=%b", tag, i, overflow, m_ovf);
            end
        end
        cap_den = 1'b0;
        @(negedge clk_in);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_pending got=%b want=1", tag, busy);
        end
    endtask

    task automatic do_swap(input bit arm_held, input string tag);
        line_end = 1'b1;
        @(negedge clk_in);
        line_end = 1'b0;
        m_sel    = ~m_sel;
        total++;
        if (swapped !== 1'b1) begin
            bad++;
            $display("FAIL %s swapped_pulse got=%b want=1", tag, swapped);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_after_swap got=%b want=0", tag, busy);
        end
        @(negedge clk_in);
        total++;
        if (swapped !== 1'b0) begin
            bad++;
            $display("FAIL %s swapped_drop got=%b want=0", tag, swapped);
        end
        total++;
        if (busy !== arm_held) begin
            bad++;
            $display("FAIL %s busy_next got=%b want=%b", tag, busy, arm_held);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; arm = 1'b0; cap_den = 1'b0; cap_stb = 1'b0; cap_bit = 1'b0;
        disp_en = 1'b1; disp_h = 11'd8; line_end = 1'b0;
        m_b0 = '0; m_b1 = '0; m_sel = 1'b0; m_ovf = 1'b0;
        repeat (3) @(negedge clk_in);
        total++;
        if ({pixel, busy, swapped, overflow} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0000", {pixel, busy, swapped, overflow});
        end
        reset = 1'b0;
        sweep(1'b1, "reset_sweep");
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_capture();
        capture(360, 1'b0, -1, 1'b1, 1'b0, "cap");
        sweep(1'b1, "cap_pend_old");
        do_swap(1'b0, "cap");
        sweep(1'b1, "cap_new");
        sweep(1'b0, "cap_disp_off");
    endtask

    task automatic test_overflow();
        capture(400, 1'b0, -1, 1'b1, 1'b0, "ovf");
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky got=%b want=1", overflow);
        end
        do_swap(1'b0, "ovf");
        sweep(1'b1, "ovf_bits");
    endtask

    task automatic test_pend_hold();
        capture(360, 1'b1, -1, 1'b1, 1'b0, "hold");
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk_in);
            if (c % 100 == 99) begin
                total++;
                if (busy !== 1'b1 || swapped !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_wait c=%0d busy=%b swapped=%b want busy=1 swapped=0",
                             c, busy, swapped);
                end
            end
        end
        sweep(1'b1, "hold_old");
        do_swap(1'b0, "hold");
        sweep(1'b1, "hold_new");
    endtask

    task automatic test_reset_mid();
        capture(360, 1'b1, 100, 1'b1, 1'b0, "abort");
        total++;
        if ({busy, overflow} !== 2'b00) begin
            bad++;
            $display("FAIL abort_state got=%b want=00", {busy, overflow});
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_in);
            total++;
            if (swapped !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_swap c=%0d swapped=%b busy=%b want 0 0", c, swapped, busy);
            end
        end
        sweep(1'b1, "abort_zero");
        capture(360, 1'b0, -1, 1'b1, 1'b0, "post_abort");
        do_swap(1'b0, "post_abort");
        sweep(1'b1, "post_abort");
    endtask

    task automatic test_arm_held();
        capture(360, 1'b1, -1, 1'b1, 1'b1, "armheld");
        do_swap(1'b1, "armheld");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_in);
            total++;
            if (swapped !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL armheld_single c=%0d swapped=%b busy=%b want 0 1", c, swapped, busy);
            end
        end
        arm = 1'b0;
        capture(200, 1'b1, -1, 1'b0, 1'b0, "armheld_next");
        do_swap(1'b0, "armheld_next");
        sweep(1'b1, "armheld_next");
    endtask

    initial begin
        test_reset();
        test_capture();
        test_overflow();
        test_pend_hold();
        test_reset_mid();
        test_arm_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
